// File: rtl/write_dest_pkg.sv
// Shared encodings and the stage entry type for the write-destination pipeline.
package write_dest_pkg;

  typedef enum logic [1:0] {
    SEL_RT   = 2'b00,
    SEL_RD   = 2'b01,
    SEL_ALT  = 2'b10,
    SEL_LINK = 2'b11
  } dest_sel_e;

  localparam int ZERO_REG     = 0;
  localparam int LINK_REG_DEF = 31;
  // Entries carry a fixed-width address field; narrower ADDR_W values are
  // zero-extended into it, so ADDR_W must not exceed this.
  localparam int ADDR_W_MAX   = 16;

  typedef struct packed {
    logic                  valid;
    logic [ADDR_W_MAX-1:0] addr;
  } dest_entry_t;

endpackage

// File: rtl/wd_stage.sv
// One write-back stage register: clear (valid only) beats hold, hold beats shift.
module wd_stage
  import write_dest_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_hold,
  input  logic        i_clear,
  input  dest_entry_t i_d,
  output dest_entry_t o_q
);

  dest_entry_t r_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q <= '0;
    end else if (i_clear) begin
      r_q.valid <= 1'b0;
    end else if (!i_hold) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/write_dest_pipe.sv
// Destination-register tracking pipeline with hazard detection and write-back.
// WRITE_DEST_PIPE_FWD_EN: when defined, the last stage is excluded from hazard compare.
module write_dest_pipe
  import write_dest_pkg::*;
#(
  parameter int ADDR_W   = 5,
  parameter int DEPTH    = 3,
  parameter int LINK_REG = LINK_REG_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       issue_valid,
  input  logic [1:0]                 selector,
  input  logic [ADDR_W-1:0]          rt_addr,
  input  logic [ADDR_W-1:0]          rd_addr,
  input  logic [ADDR_W-1:0]          alt_addr,
  input  logic                       stall,
  input  logic                       flush,
  input  logic [ADDR_W-1:0]          rs_query,
  input  logic [ADDR_W-1:0]          rt_query,
  output logic                       hazard_rs,
  output logic                       hazard_rt,
  output logic                       wb_valid,
  output logic [ADDR_W-1:0]          wb_addr,
  output logic [$clog2(DEPTH+1)-1:0] pending_count
);

  localparam int CNT_W = $clog2(DEPTH+1);
`ifdef WRITE_DEST_PIPE_FWD_EN
  localparam int HZ_STAGES = DEPTH - 1;
`else
  localparam int HZ_STAGES = DEPTH;
`endif

  logic [ADDR_W-1:0] w_sel_addr;
  dest_entry_t       w_stage_in;
  dest_entry_t       w_stage_d [DEPTH];
  dest_entry_t       w_stage_q [DEPTH];

  always_comb begin
    w_sel_addr = rt_addr;
    case (selector)
      SEL_RT:   w_sel_addr = rt_addr;
      SEL_RD:   w_sel_addr = rd_addr;
      SEL_ALT:  w_sel_addr = alt_addr;
      SEL_LINK: w_sel_addr = ADDR_W'(LINK_REG);
      default:  w_sel_addr = rt_addr;
    endcase
  end

  // Writes to $zero never become pending.
  always_comb begin
    w_stage_in.valid = issue_valid && (w_sel_addr != ADDR_W'(ZERO_REG));
    w_stage_in.addr  = ADDR_W_MAX'(w_sel_addr);
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign w_stage_d[gi] = w_stage_in;
      end else begin : g_body
        assign w_stage_d[gi] = w_stage_q[gi-1];
      end
      wd_stage u_stage (
        .clk     (clk),
        .reset   (reset),
        .i_hold  (stall),
        .i_clear (flush),
        .i_d     (w_stage_d[gi]),
        .o_q     (w_stage_q[gi])
      );
    end
  endgenerate

  always_comb begin
    hazard_rs = 1'b0;
    hazard_rt = 1'b0;
    for (int i = 0; i < HZ_STAGES; i++) begin
      if (w_stage_q[i].valid && (rs_query != '0) &&
          (w_stage_q[i].addr == ADDR_W_MAX'(rs_query)))
        hazard_rs = 1'b1;
      if (w_stage_q[i].valid && (rt_query != '0) &&
          (w_stage_q[i].addr == ADDR_W_MAX'(rt_query)))
        hazard_rt = 1'b1;
    end
  end

  always_comb begin
    pending_count = '0;
    for (int i = 0; i < DEPTH; i++)
      pending_count = pending_count + CNT_W'(w_stage_q[i].valid);
  end

  // A stalled or flushed last stage must not write; it commits on the first free cycle.
  assign wb_valid = w_stage_q[DEPTH-1].valid && !stall && !flush;
  assign wb_addr  = w_stage_q[DEPTH-1].addr[ADDR_W-1:0];

endmodule
